// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: verifies the start bit at mid-bit, samples DATA_BITS
// data bits LSB-first at bit centres, checks the stop bit and holds the word
// in a valid/ready output register. Reports framing errors and overruns as pulses.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 strt_bit,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;

  logic stop_sample;
  logic frame_done;

  // Stop-bit sample point and the good-frame condition derived from it.
  always_comb begin
    stop_sample = (state == STOP) && (cnt == FULL_M1);
    frame_done  = stop_sample && rx_in;
  end

  // Bit-timing FSM: cycle counter, bit index, shift register and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strt_bit) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_in) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // Line went back high before mid-bit: glitch, not a frame.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_in, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BW'(1);
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin // STOP
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Output word register with valid/ready handshake and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rx_in;
      overrun   <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rd_ready) begin
          // Slot free, or being emptied this very edge: take the new word.
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          // Unread word is kept; the new one is lost.
          overrun <= 1'b1;
        end
      end else if (rx_valid && rd_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with default parameters (16 clocks/bit, 8 bits).
// Each frame is replayed cycle by cycle relative to its strt_bit cycle T.
// Outputs are recorded per cycle and compared against hand-computed values.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       strt_bit;
  logic       rd_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle observations, index = cycles after T.
  logic [7:0] data_a [0:199];
  logic       rv_a   [0:199];
  logic       fe_a   [0:199];
  logic       ov_a   [0:199];
  logic       busy_a [0:199];

  uart_rx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .strt_bit(strt_bit),
    .rd_ready(rd_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int c);
    data_a[c] = rx_data;
    rv_a[c]   = rx_valid;
    fe_a[c]   = frame_err;
    ov_a[c]   = overrun;
    busy_a[c] = busy;
  endtask

  // mode 0: start bit, 8 data bits LSB-first, stop bit, then idle high.
  // mode 1: line low for 3 cycles then high (glitch).
  task automatic run_frame(input logic [7:0] data, input logic stop, input int ncyc,
                           input int mode, input logic rdy, input int rdy_at,
                           input int strt2_at, input int rst_at);
    for (int c = 0; c < ncyc; c++) begin
      if (mode == 1)       rx_in = (c < 3) ? 1'b0 : 1'b1;
      else if (c < 16)     rx_in = 1'b0;
      else if (c < 144)    rx_in = data[(c / 16) - 1];
      else if (c < 160)    rx_in = stop;
      else                 rx_in = 1'b1;
      strt_bit = (c == 0) || (c == strt2_at);
      reset    = (c == rst_at);
      rd_ready = rdy || (c == rdy_at);
      record(c);
      tick();
    end
    strt_bit = 1'b0;
    reset    = 1'b0;
    rx_in    = 1'b1;
    record(ncyc);
  endtask

  task automatic idle(input int n, input logic rdy);
    rx_in = 1'b1; strt_bit = 1'b0; rd_ready = rdy;
    for (int i = 0; i < n; i++) tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_in = 1'b1; strt_bit = 1'b0; rd_ready = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    n_checks++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b, want all 0",
               rx_data, rx_valid, frame_err, overrun, busy);
    end
    tick();
  endtask

  task automatic test_basic();
    logic bad_busy;
    logic bad_flag;
    run_frame(8'hA5, 1'b1, 153, 0, 1'b0, -1, -1, -1);
    n_checks++;
    if (rv_a[152] !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b want 0", rv_a[152]); end
    n_checks++;
    if (rv_a[153] !== 1'b1) begin n_fail++; $display("FAIL basic_valid_T153: got %b want 1", rv_a[153]); end
    n_checks++;
    if (data_a[153] !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", data_a[153]); end
    n_checks++;
    if (busy_a[0] !== 1'b0 || busy_a[153] !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_edges: got T=%b T+153=%b want 0 0", busy_a[0], busy_a[153]);
    end
    bad_busy = 1'b0;
    bad_flag = 1'b0;
    for (int c = 1; c <= 152; c++) if (busy_a[c] !== 1'b1) bad_busy = 1'b1;
    for (int c = 0; c <= 153; c++) if (fe_a[c] !== 1'b0 || ov_a[c] !== 1'b0) bad_flag = 1'b1;
    n_checks++;
    if (bad_busy) begin n_fail++; $display("FAIL basic_busy_span: got a low cycle in T+1..T+152 want all high"); end
    n_checks++;
    if (bad_flag) begin n_fail++; $display("FAIL basic_flags: got error pulse want none"); end
    idle(3, 1'b1);
  endtask

  task automatic test_false_start();
    logic bad;
    run_frame(8'h00, 1'b1, 20, 1, 1'b0, -1, -1, -1);
    n_checks++;
    if (busy_a[8] !== 1'b1 || busy_a[9] !== 1'b0) begin
      n_fail++; $display("FAIL false_busy: got T+8=%b T+9=%b want 1 0", busy_a[8], busy_a[9]);
    end
    bad = 1'b0;
    for (int c = 0; c <= 20; c++) if (rv_a[c] !== 1'b0 || fe_a[c] !== 1'b0 || ov_a[c] !== 1'b0) bad = 1'b1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL false_flags: got valid/flag high want all 0"); end
    idle(3, 1'b0);
  endtask

  task automatic test_frame_err();
    run_frame(8'h3C, 1'b0, 153, 0, 1'b0, -1, -1, -1);
    n_checks++;
    if (fe_a[152] !== 1'b0 || fe_a[153] !== 1'b1) begin
      n_fail++; $display("FAIL ferr_pulse: got T+152=%b T+153=%b want 0 1", fe_a[152], fe_a[153]);
    end
    n_checks++;
    if (rv_a[153] !== 1'b0) begin n_fail++; $display("FAIL ferr_novalid: got %b want 0", rv_a[153]); end
    run_frame(8'h5A, 1'b1, 153, 0, 1'b0, -1, -1, -1);
    n_checks++;
    if (fe_a[1] !== 1'b0) begin n_fail++; $display("FAIL ferr_one_cycle: got %b at T+154 want 0", fe_a[1]); end
    n_checks++;
    if (rv_a[153] !== 1'b1 || data_a[153] !== 8'h5A) begin
      n_fail++; $display("FAIL ferr_next_frame: got v=%b data=%h want 1 5a", rv_a[153], data_a[153]);
    end
    idle(3, 1'b1);
  endtask

  task automatic test_overrun();
    run_frame(8'h11, 1'b1, 153, 0, 1'b0, -1, -1, -1);
    n_checks++;
    if (rv_a[153] !== 1'b1 || data_a[153] !== 8'h11) begin
      n_fail++; $display("FAIL ovr_first: got v=%b data=%h want 1 11", rv_a[153], data_a[153]);
    end
    run_frame(8'h22, 1'b1, 155, 0, 1'b0, -1, -1, -1);
    n_checks++;
    if (ov_a[152] !== 1'b0 || ov_a[153] !== 1'b1 || ov_a[154] !== 1'b0) begin
      n_fail++; $display("FAIL ovr_pulse: got %b%b%b want 010", ov_a[152], ov_a[153], ov_a[154]);
    end
    n_checks++;
    if (rv_a[155] !== 1'b1 || data_a[155] !== 8'h11) begin
      n_fail++; $display("FAIL ovr_hold: got v=%b data=%h want 1 11", rv_a[155], data_a[155]);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h11) begin
      n_fail++; $display("FAIL ovr_consume: got v=%b data=%h want 0 11", rx_valid, rx_data);
    end
    idle(2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(8'h11, 1'b1, 153, 0, 1'b0, -1, -1, -1);
    run_frame(8'h22, 1'b1, 154, 0, 1'b0, 152, -1, -1);
    n_checks++;
    if (rv_a[153] !== 1'b1 || data_a[153] !== 8'h22) begin
      n_fail++; $display("FAIL b2b_replace: got v=%b data=%h want 1 22", rv_a[153], data_a[153]);
    end
    n_checks++;
    if (ov_a[153] !== 1'b0 || ov_a[154] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_no_overrun: got %b%b want 00", ov_a[153], ov_a[154]);
    end
    idle(3, 1'b1);
  endtask

  task automatic test_ignore_and_reset();
    run_frame(8'h96, 1'b1, 153, 0, 1'b0, -1, 40, -1);
    n_checks++;
    if (rv_a[153] !== 1'b1 || data_a[153] !== 8'h96) begin
      n_fail++; $display("FAIL extra_strt: got v=%b data=%h want 1 96", rv_a[153], data_a[153]);
    end
    run_frame(8'h0F, 1'b1, 62, 0, 1'b0, -1, 100, 60);
    n_checks++;
    if (busy_a[60] !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before: got %b want 1", busy_a[60]); end
    n_checks++;
    if ({data_a[61], rv_a[61], fe_a[61], ov_a[61], busy_a[61]} !== 12'h000) begin
      n_fail++; $display("FAIL rst_midframe: got data=%h v=%b fe=%b ov=%b busy=%b want all 0",
                         data_a[61], rv_a[61], fe_a[61], ov_a[61], busy_a[61]);
    end
    run_frame(8'hFF, 1'b1, 153, 0, 1'b0, -1, -1, -1);
    n_checks++;
    if (rv_a[153] !== 1'b1 || data_a[153] !== 8'hFF) begin
      n_fail++; $display("FAIL rst_next_frame: got v=%b data=%h want 1 ff", rv_a[153], data_a[153]);
    end
    idle(3, 1'b1);
  endtask

  initial begin
    reset = 1'b1; rx_in = 1'b1; strt_bit = 1'b0; rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_ignore_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive sequencer that sits behind the rx_start falling-edge detector. On each strt_bit pulse it verifies the start bit at mid-bit and samples DATA_BITS data bits LSB-first at bit centres. It then checks the stop bit and presents the received byte on a valid/ready output register, flagging framing errors and overruns.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; must be even and >= 4
DATA_BITS, 8, data bits per frame; range 5 to 9

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_in  input  1  serial line, already synchronised to clk; idle high
strt_bit  input  1  one-cycle start pulse from rx_start
rd_ready  input  1  consumer ready to accept rx_data
rx_data  output  DATA_BITS  received word, LSB = first bit on the line
rx_valid  output  1  rx_data holds an unread word
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed word dropped because rx_valid was still high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous, active-high, and takes priority over all other inputs. On reset:
  - state goes to IDLE; bit counter, cycle counter and shift register clear
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0
  - reset mid-frame abandons the frame with no flags
- Cycle counter cnt has width clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - strt_bit=1 at cycle T -> START at T+1, cnt=0
  - strt_bit is ignored in every other state
- START:
  - cnt increments each cycle
  - at cnt==HALF-1, sample rx_in; sample cycle is T+HALF
  - rx_in=0 -> DATA, cnt=0, bit index=0
  - rx_in=1 -> false start: back to IDLE, no flags
- DATA:
  - at cnt==CLKS_PER_BIT-1, sample rx_in, shift into the shift register MSB (shift right), reset cnt to 0, increment bit index
  - k-th sample (k=1..DATA_BITS) occurs at T+HALF+k*CLKS_PER_BIT
  - after sample DATA_BITS -> STOP
- STOP:
  - at cnt==CLKS_PER_BIT-1, sample rx_in at cycle S = T+HALF+(DATA_BITS+1)*CLKS_PER_BIT, then return to IDLE
  - rx_in=1 -> frame complete
  - rx_in=0 -> frame_err=1 during S+1 only; no data is delivered
- Output register on frame complete, with results visible at S+1:
  - rx_valid=0, or rx_valid=1 with rd_ready=1 at S -> rx_data loads the shift register, rx_valid=1
  - rx_valid=1 with rd_ready=0 at S -> new word discarded, rx_data unchanged, overrun=1 for one cycle
- Handshake:
  - word is consumed on any cycle with rx_valid && rd_ready; rx_valid clears next cycle unless a new word loads that same edge
  - rx_data is stable while rx_valid=1
  - rd_ready with rx_valid=0 has no effect
- busy:
  - registered, equals (state != IDLE)
  - goes high at T+1, low the cycle after the stop or false-start sample
- A new strt_bit is accepted on the first IDLE cycle after STOP, so back-to-back frames are supported.
- With defaults, rx_valid rises at T+153.

Test Plan:
1. Defaults; strt_bit at T; line carries start, 0xA5 LSB-first, stop=1, 16 cycles per bit, aligned to strt_bit -> rx_valid=1 at T+153, rx_data=0xA5, frame_err=0, busy high T+1..T+152.
2. False start: rx_in low 3 cycles then high, strt_bit pulse -> sample at T+8 sees 1, busy low from T+9, no rx_valid, no flags.
3. Frame 0x3C with stop bit 0 -> frame_err=1 for exactly cycle T+153, rx_valid stays 0, next frame 0x5A received normally.
4. rd_ready=0; frames 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun pulse at second frame's S+1, rx_valid stays 1; rd_ready=1 -> rx_valid=0 next cycle, rx_data remains 0x11.
5. rx_valid=1 (0x11) and rd_ready=1 exactly at the stop-sample cycle of frame 0x22 -> rx_data=0x22, rx_valid stays 1, overrun=0.
6. Extra strt_bit pulses during DATA are ignored (rx_data correct). Reset asserted mid-DATA -> next cycle all outputs 0, state IDLE; subsequent frame 0xFF received correctly.
